// File: rtl/dot_seq_if.sv
// Operand, processor-lane and result signals between a dot_sequencer and its neighbours.
// master = the sequencer, slave = the distributor/processor/consumer side.
interface dot_seq_if #(
  parameter int DW = 16,
  parameter int LW = 4
);
  logic          start;
  logic [LW-1:0] len;
  logic          busy;

  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  logic [DW-1:0] proc_A;
  logic [DW-1:0] proc_B;
  logic          proc_enable;
  logic          proc_retro;
  logic [DW-1:0] proc_prev;
  logic [DW-1:0] proc_out;
  logic          proc_done;

  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;

  modport master (
    input  start, len, op_valid, op_a, op_b, proc_out, proc_done, res_ready,
    output busy, op_ready, proc_A, proc_B, proc_enable, proc_retro, proc_prev,
           res_valid, res_data
  );

  modport slave (
    output start, len, op_valid, op_a, op_b, proc_out, proc_done, res_ready,
    input  busy, op_ready, proc_A, proc_B, proc_enable, proc_retro, proc_prev,
           res_valid, res_data
  );
endinterface

// File: rtl/dot_sequencer.sv
// Feeds one multiply/accumulate lane with a row of operand pairs and returns the dot product.
// Optional DOT_SEQ_LEN_CHECK_EN: reject len==0 / len>MAX_LEN with a len_err pulse instead of clamping.
module dot_sequencer #(
  parameter int DW      = 16,
  parameter int MAX_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  dot_seq_if.master bus
`ifdef DOT_SEQ_LEN_CHECK_EN
  ,
  output logic len_err
`endif
);

  localparam int            LW    = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE   = LW'(1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, RESULT} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] len_q, issued, retired;
  logic [DW-1:0] acc;
  logic [LW-1:0] eff_len;
  logic          len_ok;
  logic          hs, last_issue, last_done;

`ifdef DOT_SEQ_LEN_CHECK_EN
  always_comb begin
    len_ok  = (bus.len != '0) && (bus.len <= MAX_L);
    eff_len = bus.len;
  end
`else
  // Out-of-range lengths run a full-width row rather than being refused.
  always_comb begin
    len_ok  = 1'b1;
    eff_len = ((bus.len == '0) || (bus.len > MAX_L)) ? MAX_L : bus.len;
  end
`endif

  assign hs         = bus.op_valid & bus.op_ready;
  assign last_issue = hs && (issued == len_q - ONE);
  assign last_done  = bus.proc_done && (retired == len_q - ONE);

  // The lane zeroes its out when idle, so the running sum lives in acc; the
  // bypass hands the fresh partial sum straight to a back-to-back issue.
  assign bus.proc_prev = bus.proc_done ? bus.proc_out : acc;

  // NOTE: state-holding processes use non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start && len_ok) state_nxt = FEED;
      FEED:    if (last_issue)          state_nxt = DRAIN;
      DRAIN:   if (last_done)           state_nxt = RESULT;
      RESULT:  if (bus.res_ready)       state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    bus.busy      = 1'b0;
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    unique case (state)
      IDLE:    ;
      FEED:    begin bus.busy = 1'b1; bus.op_ready = (issued < len_q); end
      DRAIN:   bus.busy = 1'b1;
      RESULT:  begin bus.busy = 1'b1; bus.res_valid = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q           <= '0;
      issued          <= '0;
      retired         <= '0;
      acc             <= '0;
      bus.proc_A      <= '0;
      bus.proc_B      <= '0;
      bus.proc_enable <= 1'b0;
      bus.proc_retro  <= 1'b0;
      bus.res_data    <= '0;
    end else begin
      bus.proc_enable <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && len_ok) begin
            len_q   <= eff_len;
            issued  <= '0;
            retired <= '0;
            acc     <= '0;
          end
        end
        FEED: begin
          if (hs) begin
            bus.proc_A      <= bus.op_a;
            bus.proc_B      <= bus.op_b;
            bus.proc_enable <= 1'b1;
            bus.proc_retro  <= (issued != '0);
            issued          <= issued + ONE;
          end
        end
        default: ;
      endcase

      if (bus.proc_done && (state != IDLE)) begin
        acc     <= bus.proc_out;
        retired <= retired + ONE;
      end

      if ((state == DRAIN) && last_done) bus.res_data <= bus.proc_out;
    end
  end

`ifdef DOT_SEQ_LEN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) len_err <= 1'b0;
    else      len_err <= (state == IDLE) && bus.start && !len_ok;
  end
`endif

endmodule

// File: tb/tb_dot_sequencer.sv
// Directed bench for dot_sequencer with a one-cycle MAC lane model and a row-level
// scoreboard (pair order, retro flag, forwarded partial sum, result value and latency).
module tb_dot_sequencer;

  localparam int DW      = 16;
  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic clk;
  logic rst;
`ifdef DOT_SEQ_LEN_CHECK_EN
  logic len_err;
`endif

  dot_seq_if #(.DW(DW), .LW(LW)) b ();

  dot_sequencer #(.DW(DW), .MAX_LEN(MAX_LEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (b)
`ifdef DOT_SEQ_LEN_CHECK_EN
    ,
    .len_err (len_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Processor lane: one-cycle MAC, out returns to 0 when not enabled.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      b.proc_done <= 1'b0;
      b.proc_out  <= '0;
    end else begin
      b.proc_done <= b.proc_enable;
      b.proc_out  <= b.proc_enable
                   ? DW'(b.proc_A * b.proc_B + (b.proc_retro ? b.proc_prev : '0))
                   : '0;
    end
  end

  // Row-level reference: pairs in handshake order, running sum, expected results.
  logic [31:0]   pq[$];
  logic [DW-1:0] eq[$];
  int            row_len, row_idx, hs_cnt, cyc, last_hs_cyc;
  logic [DW-1:0] psum;
  logic          prev_rv, prev_rhs;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      pq.delete(); eq.delete();
      row_len = 0; row_idx = 0; hs_cnt = 0; psum = '0;
      prev_rv = 1'b0; prev_rhs = 1'b0;
    end else begin
      if (prev_rhs) begin
        check("idle_after_ack_busy",  b.busy,      1'b0);
        check("idle_after_ack_valid", b.res_valid, 1'b0);
      end else if (prev_rv) begin
        check("res_valid_held", b.res_valid, 1'b1);
      end

      if (b.res_valid) begin
        if (eq.size() == 0) check("unexpected_result", 1'b1, 1'b0);
        else                check("res_data_model", b.res_data, eq[0]);
        if (!prev_rv) check("result_latency", cyc - last_hs_cyc, 3);
      end
      prev_rhs = b.res_valid && b.res_ready;
      if (prev_rhs && eq.size() != 0) void'(eq.pop_front());
      prev_rv = b.res_valid;

      if (b.proc_enable) begin
        if (pq.size() == 0) begin
          check("unexpected_enable", 1'b1, 1'b0);
        end else begin
          logic [31:0]   pr;
          logic [DW-1:0] ea, eb;
          pr = pq.pop_front();
          ea = pr[31:16];
          eb = pr[15:0];
          check("proc_A", b.proc_A, ea);
          check("proc_B", b.proc_B, eb);
          check("proc_retro", b.proc_retro, row_idx != 0);
          if (row_idx != 0) check("proc_prev", b.proc_prev, psum);
          psum = DW'(psum + ea * eb);
          row_idx++;
          if (row_idx == row_len) eq.push_back(psum);
        end
      end

      if (b.op_valid && b.op_ready) begin
        pq.push_back({b.op_a, b.op_b});
        hs_cnt++;
        if (hs_cnt == row_len) last_hs_cyc = cyc;
      end

      if (b.start && !b.busy) begin
        int l;
        l = int'(b.len);
`ifdef DOT_SEQ_LEN_CHECK_EN
        if (l != 0 && l <= MAX_LEN) begin
          row_len = l; row_idx = 0; hs_cnt = 0; psum = '0;
        end
`else
        row_len = (l == 0 || l > MAX_LEN) ? MAX_LEN : l;
        row_idx = 0; hs_cnt = 0; psum = '0;
`endif
      end
    end
  end

  logic [DW-1:0] pa[MAX_LEN];
  logic [DW-1:0] pb[MAX_LEN];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [LW-1:0] l);
    b.start = 1'b1;
    b.len   = l;
    tick();
    b.start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      logic ok;
      int   guard;
      b.op_valid = 1'b1;
      b.op_a     = pa[i];
      b.op_b     = pb[i];
      guard      = 0;
      ok         = 1'b0;
      do begin
        @(negedge clk);
        ok = b.op_ready;
        tick();
        guard++;
      end while (!ok && guard < 50);
      b.op_valid = 1'b0;
      if (!ok) begin
        check("feed_timeout", 1'b0, 1'b1);
        return;
      end
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic wait_result(input logic [DW-1:0] exp, input string nm, input int stall);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = b.res_valid;
    end
    if (!seen) begin
      check({nm, "_timeout"}, 1'b0, 1'b1);
      return;
    end
    check(nm, b.res_data, exp);
    for (int i = 0; i < stall; i++) begin
      b.res_ready = 1'b0;
      b.start     = (i % 2 == 0);
      b.len       = LW'(3);
      tick();
    end
    b.start     = 1'b0;
    b.res_ready = 1'b1;
    tick();
    b.res_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    b.start    = 1'b0;
    b.len      = '0;
    b.op_valid = 1'b0;
    b.op_a     = '0;
    b.op_b     = '0;
    b.res_ready = 1'b0;
    cyc = 0; last_hs_cyc = 0;

    repeat (2) @(negedge clk);
    check("rst_busy",        b.busy,        1'b0);
    check("rst_op_ready",    b.op_ready,    1'b0);
    check("rst_proc_enable", b.proc_enable, 1'b0);
    check("rst_proc_retro",  b.proc_retro,  1'b0);
    check("rst_proc_A",      b.proc_A,      16'h0);
    check("rst_proc_prev",   b.proc_prev,   16'h0);
    check("rst_res_valid",   b.res_valid,   1'b0);
    check("rst_res_data",    b.res_data,    16'h0);
`ifdef DOT_SEQ_LEN_CHECK_EN
    check("rst_len_err",     len_err,       1'b0);
`endif
    tick();
    rst = 1'b1;
    tick();

    // 1: abandon a row mid-FEED, then a clean single-element row.
    pa[0] = 16'd7; pb[0] = 16'd7; pa[1] = 16'd9; pb[1] = 16'd9;
    do_start(LW'(4));
    feed(2, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t1_busy_in_reset", b.busy, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("t1_busy_after_reset", b.busy, 1'b0);
    pa[0] = 16'd5; pb[0] = 16'd5;
    do_start(LW'(1));
    feed(1, 0);
    wait_result(16'd25, "t1_res", 0);

    // 2: back-to-back row of three.
    pa[0] = 16'd1; pb[0] = 16'd2;
    pa[1] = 16'd3; pb[1] = 16'd4;
    pa[2] = 16'd5; pb[2] = 16'd6;
    b.res_ready = 1'b1;
    do_start(LW'(3));
    feed(3, 0);
    wait_result(16'd44, "t2_res", 0);

    // 3: same row with two idle cycles between pairs.
    do_start(LW'(3));
    feed(3, 2);
    wait_result(16'd44, "t3_res", 0);

    // 4: product wraps at DW bits.
    pa[0] = 16'hFFFF; pb[0] = 16'd2;
    do_start(LW'(1));
    feed(1, 0);
    wait_result(16'hFFFE, "t4_res", 0);

    // 5: consumer stalls 5 cycles while start is pulsed; both must be ignored.
    pa[0] = 16'd2; pb[0] = 16'd3;
    pa[1] = 16'd4; pb[1] = 16'd5;
    do_start(LW'(2));
    feed(2, 0);
    wait_result(16'd26, "t5_res", 5);
    @(negedge clk);
    check("t5_idle_busy",     b.busy,     1'b0);
    check("t5_idle_op_ready", b.op_ready, 1'b0);
    tick();

    // 6: zero length.
`ifdef DOT_SEQ_LEN_CHECK_EN
    for (int k = 0; k < 2; k++) begin
      do_start(k == 0 ? LW'(0) : LW'(MAX_LEN + 1));
      @(negedge clk);
      check("t6_len_err_pulse", len_err, 1'b1);
      check("t6_busy",          b.busy,  1'b0);
      @(negedge clk);
      check("t6_len_err_clear", len_err, 1'b0);
      check("t6_busy_later",    b.busy,  1'b0);
      tick();
    end
`else
    for (int i = 0; i < MAX_LEN; i++) begin
      pa[i] = 16'd1; pb[i] = 16'd1;
    end
    do_start(LW'(0));
    feed(MAX_LEN, 0);
    wait_result(16'd8, "t6_res", 0);
`endif

    repeat (3) tick();
    check("end_busy",      b.busy,      1'b0);
    check("end_res_valid", b.res_valid, 1'b0);
    check("end_queue_empty", eq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
